seq_bool_truth_lut: RTL and testbench

Parametrised, run-time-programmable successor to the single-bit sequential truth-table flop. It holds NBITS independent one-bit state channels. At each enabled clock edge, each channel computes its next state from a 4-entry truth table indexed by {a[i], q[i]}. The tables are programmed through a valid/ready configuration port into a shadow bank and applied atomically by a commit. The block sits wherever the design needs a bank of small programmable sequential boolean functions, such as flag trackers and sticky/toggle bits.

---
 rtl/seq_bool_truth_lut.sv | 114 +++++++++++
 tb/tb_seq_bool_truth_lut.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_bool_truth_lut.sv
// seq_bool_truth_lut: bank of NBITS one-bit state channels, each advanced
// by a run-time programmable 4-entry truth table indexed by {a[i], q[i]}.
//
// Ports:
//   clk, reset  - clock; synchronous active-high reset
//   en          - state-update enable
//   a           - per-channel data input
//   cfg_val/rdy - config handshake; fires on cfg_val && cfg_rdy
//   cfg_op      - 0 = write shadow entry, 1 = commit shadow to active
//   cfg_idx     - channel index for a shadow write
//   cfg_tbl     - truth table for a shadow write
//   cfg_dirty   - shadow differs from last commit/reset contents
//   q           - registered channel state
module seq_bool_truth_lut #(
  parameter int               NBITS       = 4,
  parameter logic [NBITS-1:0] RESET_Q     = '0,
  parameter logic [3:0]       DEFAULT_TBL = 4'b1110,
  localparam int              IDXW        =
    (NBITS > 1) ? $clog2(NBITS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [NBITS-1:0] a,
  input  logic             cfg_val,
  output logic             cfg_rdy,
  input  logic             cfg_op,
  input  logic [IDXW-1:0]  cfg_idx,
  input  logic [3:0]       cfg_tbl,
  output logic             cfg_dirty,
  output logic [NBITS-1:0] q
);

  typedef enum logic {
    ST_READY,
    ST_BUSY
  } cfg_st_e;

  cfg_st_e st_q;
  cfg_st_e st_d;

  logic [NBITS-1:0][3:0] act_tbl;
  logic [NBITS-1:0][3:0] shd_tbl;
  logic [NBITS-1:0]      q_d;
  logic [NBITS-1:0]      wr_sel;
  logic                  fire;
  logic                  wr_fire;
  logic                  cm_fire;
  logic                  idx_ok;
  logic                  dirty_q;

  assign cfg_rdy   = (st_q == ST_READY);
  assign cfg_dirty = dirty_q;

  assign fire    = cfg_val && cfg_rdy;
  assign wr_fire = fire && !cfg_op;
  assign cm_fire = fire && cfg_op;

  // One-hot channel select; an index past the last channel selects
  // nothing, which drops the write while the handshake still completes.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NBITS; i++) begin
      wr_sel[i] = (cfg_idx == IDXW'(i));
    end
  end

  assign idx_ok = |wr_sel;

  always_comb begin
    q_d = q;
    for (int i = 0; i < NBITS; i++) begin
      q_d[i] = act_tbl[i][{a[i], q[i]}];
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_READY: if (cm_fire) st_d = ST_BUSY;
      ST_BUSY:  st_d = ST_READY;
      default:  st_d = ST_READY;
    endcase
  end

  // Reset parks the port in BUSY so cfg_rdy reads 0 for the reset cycle
  // and rises on the first edge after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= ST_BUSY;
      q       <= RESET_Q;
      dirty_q <= 1'b0;
      for (int i = 0; i < NBITS; i++) begin
        act_tbl[i] <= DEFAULT_TBL;
        shd_tbl[i] <= DEFAULT_TBL;
      end
    end else begin
      st_q <= st_d;
      // Update reads act_tbl before the commit below lands, so a
      // colliding commit only governs later edges.
      if (en) q <= q_d;
      if (cm_fire) begin
        act_tbl <= shd_tbl;
        dirty_q <= 1'b0;
      end else if (wr_fire && idx_ok) begin
        dirty_q <= 1'b1;
      end
      for (int i = 0; i < NBITS; i++) begin
        if (wr_fire && wr_sel[i]) shd_tbl[i] <= cfg_tbl;
      end
    end
  end

endmodule

// File: tb/tb_seq_bool_truth_lut.sv
// tb_seq_bool_truth_lut: scoreboard bench for seq_bool_truth_lut.
// Runs a 4-channel and a 3-channel instance with directed vectors.
module tb_seq_bool_truth_lut;

  typedef struct {
    int         tag;
    logic [3:0] q;
    logic       rdy;
    logic       dirty;
  } exp_t;

  logic clk;

  logic       reset4, en4, val4, op4, rdy4, dirty4;
  logic [3:0] a4, tbl4, q4;
  logic [1:0] idx4;

  logic       reset3, en3, val3, op3, rdy3, dirty3;
  logic [2:0] a3, q3;
  logic [3:0] tbl3;
  logic [1:0] idx3;

  exp_t sb4[$];
  exp_t sb3[$];
  exp_t e4, e3;
  int   tag4, tag3;
  int   checks, errors;

  seq_bool_truth_lut #(.NBITS(4)) dut4 (
    .clk(clk), .reset(reset4), .en(en4), .a(a4),
    .cfg_val(val4), .cfg_rdy(rdy4), .cfg_op(op4),
    .cfg_idx(idx4), .cfg_tbl(tbl4), .cfg_dirty(dirty4),
    .q(q4)
  );

  seq_bool_truth_lut #(.NBITS(3)) dut3 (
    .clk(clk), .reset(reset3), .en(en3), .a(a3),
    .cfg_val(val3), .cfg_rdy(rdy3), .cfg_op(op3),
    .cfg_idx(idx3), .cfg_tbl(tbl3), .cfg_dirty(dirty3),
    .q(q3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step4(
    input logic r, e, input logic [3:0] av,
    input logic v, o, input logic [1:0] ix,
    input logic [3:0] tb,
    input logic [3:0] eq, input logic er, ed
  );
    exp_t x;
    @(negedge clk);
    reset4 = r; en4 = e; a4 = av;
    val4 = v; op4 = o; idx4 = ix; tbl4 = tb;
    x.tag = tag4; x.q = eq; x.rdy = er; x.dirty = ed;
    sb4.push_back(x);
    tag4++;
  endtask

  task automatic step3(
    input logic r, e, input logic [2:0] av,
    input logic v, o, input logic [1:0] ix,
    input logic [3:0] tb,
    input logic [2:0] eq, input logic er, ed
  );
    exp_t x;
    @(negedge clk);
    reset3 = r; en3 = e; a3 = av;
    val3 = v; op3 = o; idx3 = ix; tbl3 = tb;
    x.tag = tag3; x.q = {1'b0, eq}; x.rdy = er; x.dirty = ed;
    sb3.push_back(x);
    tag3++;
  endtask

  always begin
    @(posedge clk);
    #2;
    if (sb4.size() > 0) begin
      e4 = sb4.pop_front();
      checks++;
      if (q4 !== e4.q || rdy4 !== e4.rdy || dirty4 !== e4.dirty) begin
        errors++;
        $display("FAIL n4 step %0d: got q=%b rdy=%b dirty=%b, want q=%b rdy=%b dirty=%b",
                 e4.tag, q4, rdy4, dirty4, e4.q, e4.rdy, e4.dirty);
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (sb3.size() > 0) begin
      e3 = sb3.pop_front();
      checks++;
      if ({1'b0, q3} !== e3.q || rdy3 !== e3.rdy ||
          dirty3 !== e3.dirty) begin
        errors++;
        $display("FAIL n3 step %0d: got q=%b rdy=%b dirty=%b, want q=%b rdy=%b dirty=%b",
                 e3.tag, q3, rdy3, dirty3, e3.q[2:0], e3.rdy, e3.dirty);
      end
    end
  end

  initial begin
    checks = 0; errors = 0; tag4 = 0; tag3 = 0;
    reset4 = 1; en4 = 0; a4 = '0; val4 = 0; op4 = 0;
    idx4 = '0; tbl4 = '0;
    reset3 = 1; en3 = 0; a3 = '0; val3 = 0; op3 = 0;
    idx3 = '0; tbl3 = '0;

    // reset state, default sticky OR, enable hold
    step4(1,0,4'b0000, 0,0,2'd0,4'h0, 4'b0000,0,0);
    step4(0,1,4'b0000, 0,0,2'd0,4'h0, 4'b0000,1,0);
    step4(0,1,4'b0001, 0,0,2'd0,4'h0, 4'b0001,1,0);
    step4(0,1,4'b0000, 0,0,2'd0,4'h0, 4'b0001,1,0);
    step4(0,1,4'b0110, 0,0,2'd0,4'h0, 4'b0111,1,0);
    step4(0,0,4'b1000, 0,0,2'd0,4'h0, 4'b0111,1,0);
    // shadow isolation: ch0 toggle written, not committed
    step4(0,0,4'b0000, 1,0,2'd0,4'b0110, 4'b0111,1,1);
    step4(0,1,4'b0001, 0,0,2'd0,4'h0, 4'b0111,1,1);
    step4(0,1,4'b0001, 0,0,2'd0,4'h0, 4'b0111,1,1);
    // commit colliding with update: old table this edge
    step4(0,1,4'b0001, 1,1,2'd0,4'h0, 4'b0111,0,0);
    // write held through busy cycle, toggle now active
    step4(0,1,4'b0001, 1,0,2'd1,4'b0110, 4'b0110,1,0);
    step4(0,0,4'b0000, 1,0,2'd1,4'b0110, 4'b0110,1,1);
    step4(0,0,4'b0000, 1,0,2'd2,4'b0000, 4'b0110,1,1);
    step4(0,0,4'b0000, 1,0,2'd3,4'b0101, 4'b0110,1,1);
    step4(0,1,4'b0000, 1,1,2'd0,4'h0, 4'b0110,0,0);
    step4(0,1,4'b1111, 0,0,2'd0,4'h0, 4'b1001,1,0);
    step4(0,1,4'b0000, 0,0,2'd0,4'h0, 4'b0001,1,0);
    // clean commit still drops cfg_rdy
    step4(0,0,4'b0000, 1,1,2'd0,4'h0, 4'b0001,0,0);
    step4(0,0,4'b0000, 0,0,2'd0,4'h0, 4'b0001,1,0);
    // restore OR on ch2/ch3 and drive q to 1111
    step4(0,1,4'b0000, 1,0,2'd2,4'b1110, 4'b1001,1,1);
    step4(0,1,4'b0110, 1,0,2'd3,4'b1110, 4'b0011,1,1);
    step4(0,1,4'b0100, 1,1,2'd0,4'h0, 4'b1011,0,0);
    step4(0,1,4'b0100, 0,0,2'd0,4'h0, 4'b1111,1,0);
    step4(0,0,4'b0000, 1,0,2'd0,4'b0000, 4'b1111,1,1);
    step4(0,0,4'b0000, 1,1,2'd0,4'h0, 4'b1111,0,0);
    // reset inside busy cycle with a write request present
    step4(1,1,4'b1111, 1,0,2'd1,4'b0000, 4'b0000,0,0);
    step4(0,0,4'b0000, 0,0,2'd0,4'h0, 4'b0000,1,0);
    step4(0,1,4'b0001, 1,0,2'd1,4'b0000, 4'b0001,1,1);
    // reset discards dirty shadow
    step4(1,1,4'b1111, 0,0,2'd0,4'h0, 4'b0000,0,0);
    step4(0,0,4'b0000, 1,1,2'd0,4'h0, 4'b0000,1,0);
    step4(0,1,4'b0101, 1,1,2'd0,4'h0, 4'b0101,0,0);
    step4(0,1,4'b0010, 0,0,2'd0,4'h0, 4'b0111,1,0);
    step4(0,1,4'b0000, 0,0,2'd0,4'h0, 4'b0111,1,0);

    // out-of-range index on the 3-channel build
    step3(1,0,3'b000, 0,0,2'd0,4'h0, 3'b000,0,0);
    step3(0,0,3'b000, 0,0,2'd0,4'h0, 3'b000,1,0);
    step3(0,1,3'b001, 1,0,2'd3,4'b0000, 3'b001,1,0);
    step3(0,1,3'b010, 1,1,2'd0,4'h0, 3'b011,0,0);
    step3(0,1,3'b100, 0,0,2'd0,4'h0, 3'b111,1,0);
    step3(0,1,3'b000, 0,0,2'd0,4'h0, 3'b111,1,0);

    repeat (3) @(negedge clk);
    if (sb4.size() != 0 || sb3.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, want 0/0",
               sb4.size(), sb3.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
